uart_main_controller: RTL and testbench

Central FSM of the UART controller, between the host register interface, the RX/TX FIFOs and the transmitter/receiver. In normal operation it forwards host FIFO reads and writes and collects line errors. It also runs the configuration handshake with the remote UART, either as master (local host initiates) or as slave (remote device initiates), and drives the active line configuration.

---
 rtl/uart_main_controller_pkg.sv | 52 +++++
 rtl/uart_main_controller.sv | 270 +++++++++++++++++++++++++++
 tb/tb_uart_main_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_main_controller_pkg.sv
// Shared constants, types and packet helper for the UART main controller.
// Packets on the configuration link are {id[1:0], 4'b0000, option[1:0]}.
package UART_pkg;

    localparam int         RX_FIFO_DEPTH = 16;
    localparam logic [7:0] ACKN_PKT      = 8'hFF;

    localparam logic [1:0] END_CONFIGURATION_ID = 2'b00;
    localparam logic [1:0] DATA_WIDTH_ID        = 2'b01;
    localparam logic [1:0] PARITY_MODE_ID       = 2'b10;
    localparam logic [1:0] STOP_BITS_ID         = 2'b11;

    localparam logic [1:0] STD_DATA_WIDTH  = 2'b11;
    localparam logic [1:0] STD_PARITY_MODE = 2'b00;
    localparam logic [1:0] STD_STOP_BITS   = 2'b00;

    typedef struct packed {
        logic [1:0] dataWidth;
        logic [1:0] parityMode;
        logic [1:0] stopBits;
    } uartConfig_t;

    localparam uartConfig_t STD_CONFIG = '{dataWidth:  STD_DATA_WIDTH,
                                           parityMode: STD_PARITY_MODE,
                                           stopBits:   STD_STOP_BITS};

    typedef enum logic [2:0] {
        ERR_NONE    = 3'b000,
        ERR_FRAME   = 3'b001,
        ERR_PARITY  = 3'b010,
        ERR_OVERRUN = 3'b011,
        ERR_CONFIG  = 3'b100
    } uartError_t;

    typedef enum logic [3:0] {
        ST_MAIN              = 4'd0,
        ST_REQ_MST           = 4'd1,
        ST_WAIT_REQ_ACKN_MST = 4'd2,
        ST_SETUP_MST         = 4'd3,
        ST_WAIT_TX_MST       = 4'd4,
        ST_WAIT_ACKN_MST     = 4'd5,
        ST_WAIT_REQ_ACKN_SLV = 4'd6,
        ST_WAIT_TX_SLV       = 4'd7,
        ST_SETUP_SLV         = 4'd8,
        ST_SEND_ACKN_SLV     = 4'd9
    } uartState_t;

    function automatic logic [7:0] assemble_packet(input logic [1:0] id, input logic [1:0] option);
        return {id, 4'b0000, option};
    endfunction

endpackage

// File: rtl/uart_main_controller.sv
// Central UART FSM: host FIFO forwarding, error latching and master/slave configuration handshake.
// Optional macro CONFIG_ACKN_CHECK_EN: received ack bytes must equal ACKN_PKT, otherwise the handshake aborts.
module uart_main_controller
    import UART_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       interrupt_ackn_i,
    input  logic [7:0] data_rx_i,
    input  logic [7:0] data_tx_i,
    input  logic       tx_done_i,
    input  logic       req_done_i,
    input  logic       frame_error_i,
    input  logic       parity_i,
    input  logic       overrun_error_i,
    input  logic       configuration_error_i,
    input  logic       rx_fifo_empty_i,
    input  logic       tx_fifo_empty_i,
    input  logic       rx_fifo_read_i,
    input  logic       tx_fifo_write_i,
    input  logic       config_req_slv_i,
    input  logic       config_req_mst_i,
    input  logic       std_config_i,
    input  logic [5:0] config_i,
    input  logic       data_stream_mode_i,
    input  logic       req_ackn_i,
    output logic       STR_en_o,
    output logic [5:0] config_o,
    output logic       config_req_mst_o,
    output logic       data_stream_mode_o,
    output logic       configuration_done_o,
    output logic       req_ackn_o,
    output logic       rx_fifo_read_o,
    output logic       tx_fifo_write_o,
    output logic [7:0] data_tx_o,
    output logic [2:0] error_o
);

    uartState_t  stateR, nextStateS;
    uartConfig_t configR, shadowR;
    uartError_t  errorR, newErrS;
    logic [1:0]  pktIdxR;
    logic        endSeenR, cfgReqMstR, streamModeR, cfgDoneR, reqAcknR;
    logic        acknOkS, ackMismatchS, abortS, inConfigS;
    logic        rxPopS, txWriteS;
    logic [7:0]  txDataS, mstPktS;

`ifdef CONFIG_ACKN_CHECK_EN
    assign acknOkS = (data_rx_i == ACKN_PKT);
`else
    assign acknOkS = 1'b1;
`endif

    assign inConfigS    = (stateR != ST_MAIN);
    assign ackMismatchS = ((stateR == ST_WAIT_REQ_ACKN_MST) || (stateR == ST_WAIT_ACKN_MST))
                          && !rx_fifo_empty_i && !acknOkS;
    assign abortS       = inConfigS && (configuration_error_i || ackMismatchS);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stateR <= ST_MAIN;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Next-state logic; an abort overrides every configuration state
    always_comb begin
        nextStateS = stateR;
        if (abortS) begin
            nextStateS = ST_MAIN;
        end else begin
            case (stateR)
                ST_MAIN: begin
                    if (config_req_slv_i)      nextStateS = ST_WAIT_REQ_ACKN_SLV;
                    else if (config_req_mst_i) nextStateS = ST_REQ_MST;
                    else                       nextStateS = ST_MAIN;
                end
                ST_REQ_MST: begin
                    if (req_done_i) nextStateS = ST_WAIT_REQ_ACKN_MST;
                    else            nextStateS = ST_REQ_MST;
                end
                ST_WAIT_REQ_ACKN_MST: begin
                    if (!rx_fifo_empty_i) nextStateS = ST_SETUP_MST;
                    else                  nextStateS = ST_WAIT_REQ_ACKN_MST;
                end
                ST_SETUP_MST: nextStateS = ST_WAIT_TX_MST;
                ST_WAIT_TX_MST: begin
                    if (tx_done_i) nextStateS = ST_WAIT_ACKN_MST;
                    else           nextStateS = ST_WAIT_TX_MST;
                end
                ST_WAIT_ACKN_MST: begin
                    if (rx_fifo_empty_i)        nextStateS = ST_WAIT_ACKN_MST;
                    else if (pktIdxR == 2'd3)   nextStateS = ST_MAIN;
                    else                        nextStateS = ST_SETUP_MST;
                end
                ST_WAIT_REQ_ACKN_SLV: begin
                    if (req_ackn_i) nextStateS = ST_WAIT_TX_SLV;
                    else            nextStateS = ST_WAIT_REQ_ACKN_SLV;
                end
                ST_WAIT_TX_SLV: begin
                    if (!tx_done_i)    nextStateS = ST_WAIT_TX_SLV;
                    else if (endSeenR) nextStateS = ST_MAIN;
                    else               nextStateS = ST_SETUP_SLV;
                end
                ST_SETUP_SLV: begin
                    if (!rx_fifo_empty_i) nextStateS = ST_SEND_ACKN_SLV;
                    else                  nextStateS = ST_SETUP_SLV;
                end
                ST_SEND_ACKN_SLV: nextStateS = ST_WAIT_TX_SLV;
                default:          nextStateS = ST_MAIN;
            endcase
        end
    end

    // Outgoing master packet for the current index; index 3 is the END packet
    always_comb begin
        case (pktIdxR)
            2'd0:    mstPktS = assemble_packet(DATA_WIDTH_ID, shadowR.dataWidth);
            2'd1:    mstPktS = assemble_packet(PARITY_MODE_ID, shadowR.parityMode);
            2'd2:    mstPktS = assemble_packet(STOP_BITS_ID, shadowR.stopBits);
            default: mstPktS = assemble_packet(END_CONFIGURATION_ID, 2'b00);
        endcase
    end

    // FIFO strobes and TX data, combinational from state and inputs
    always_comb begin
        rxPopS   = 1'b0;
        txWriteS = 1'b0;
        txDataS  = 8'h00;
        case (stateR)
            ST_MAIN: begin
                rxPopS   = rx_fifo_read_i & ~rx_fifo_empty_i;
                txWriteS = tx_fifo_write_i;
                txDataS  = data_tx_i;
            end
            ST_WAIT_REQ_ACKN_MST, ST_WAIT_ACKN_MST, ST_SETUP_SLV: begin
                rxPopS = ~rx_fifo_empty_i;
            end
            ST_SETUP_MST: begin
                txWriteS = 1'b1;
                txDataS  = mstPktS;
            end
            ST_WAIT_REQ_ACKN_SLV: begin
                txWriteS = req_ackn_i;
                txDataS  = ACKN_PKT;
            end
            ST_SEND_ACKN_SLV: begin
                txWriteS = 1'b1;
                txDataS  = ACKN_PKT;
            end
            default: begin
                rxPopS   = 1'b0;
                txWriteS = 1'b0;
                txDataS  = 8'h00;
            end
        endcase
    end

    // Configuration datapath: shadow register, packet index, active configuration and pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            configR    <= STD_CONFIG;
            shadowR    <= STD_CONFIG;
            pktIdxR    <= 2'd0;
            endSeenR   <= 1'b0;
            cfgReqMstR <= 1'b0;
            cfgDoneR   <= 1'b0;
            reqAcknR   <= 1'b0;
        end else begin
            cfgDoneR <= 1'b0;
            reqAcknR <= 1'b0;
            if (abortS) begin
                pktIdxR    <= 2'd0;
                endSeenR   <= 1'b0;
                cfgReqMstR <= 1'b0;
            end else begin
                case (stateR)
                    ST_MAIN: begin
                        if (config_req_slv_i) begin
                            shadowR  <= configR;
                            endSeenR <= 1'b0;
                            reqAcknR <= 1'b1;
                        end else if (config_req_mst_i) begin
                            shadowR    <= uartConfig_t'(config_i);
                            pktIdxR    <= 2'd0;
                            cfgReqMstR <= 1'b1;
                        end else if (std_config_i) begin
                            configR <= STD_CONFIG;
                        end
                    end
                    ST_WAIT_ACKN_MST: begin
                        if (!rx_fifo_empty_i) begin
                            if (pktIdxR == 2'd3) begin
                                configR    <= shadowR;
                                cfgDoneR   <= 1'b1;
                                cfgReqMstR <= 1'b0;
                                pktIdxR    <= 2'd0;
                            end else begin
                                pktIdxR <= pktIdxR + 2'd1;
                            end
                        end
                    end
                    ST_WAIT_TX_SLV: begin
                        if (tx_done_i && endSeenR) begin
                            configR  <= shadowR;
                            cfgDoneR <= 1'b1;
                            endSeenR <= 1'b0;
                        end
                    end
                    ST_SETUP_SLV: begin
                        if (!rx_fifo_empty_i) begin
                            case (data_rx_i[7:6])
                                DATA_WIDTH_ID:  shadowR.dataWidth  <= data_rx_i[1:0];
                                PARITY_MODE_ID: shadowR.parityMode <= data_rx_i[1:0];
                                STOP_BITS_ID:   shadowR.stopBits   <= data_rx_i[1:0];
                                default:        endSeenR           <= 1'b1;
                            endcase
                        end
                    end
                    default: begin
                        pktIdxR <= pktIdxR;
                    end
                endcase
            end
        end
    end

    // Highest-priority active error; an abort counts as a configuration error
    always_comb begin
        if (configuration_error_i || abortS) newErrS = ERR_CONFIG;
        else if (overrun_error_i)            newErrS = ERR_OVERRUN;
        else if (frame_error_i)              newErrS = ERR_FRAME;
        else if (parity_i)                   newErrS = ERR_PARITY;
        else                                 newErrS = ERR_NONE;
    end

    // Error latch: a new error in the same cycle beats the host clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            errorR <= ERR_NONE;
        end else if (newErrS != ERR_NONE) begin
            errorR <= newErrS;
        end else if (interrupt_ackn_i) begin
            errorR <= ERR_NONE;
        end
    end

    // Stream-mode register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            streamModeR <= 1'b0;
        end else begin
            streamModeR <= data_stream_mode_i;
        end
    end

    assign STR_en_o             = (stateR == ST_REQ_MST);
    assign config_o             = configR;
    assign config_req_mst_o     = cfgReqMstR;
    assign data_stream_mode_o   = streamModeR;
    assign configuration_done_o = cfgDoneR;
    assign req_ackn_o           = reqAcknR;
    assign rx_fifo_read_o       = rxPopS;
    assign tx_fifo_write_o      = txWriteS;
    assign data_tx_o            = txDataS;
    assign error_o              = errorR;

endmodule

// File: tb/tb_uart_main_controller.sv
// Self-checking bench for uart_main_controller: random MAIN traffic, master and slave
// handshakes driven by a small remote-UART model, error latching and abort behaviour.
module tb_uart_main_controller;

    localparam logic [5:0] STD_CFG = 6'b11_00_00;
    localparam logic [7:0] ACK     = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       interrupt_ackn, tx_done, req_done;
    logic       frame_err, parity_err, overrun_err, config_err;
    logic       rx_empty, tx_empty, rx_read, tx_write;
    logic       req_slv, req_mst, std_cfg, stream_mode, req_ackn;
    logic [7:0] data_rx, data_tx;
    logic [5:0] cfg_in;
    logic       str_en, cfg_req_mst_o, stream_mode_o, cfg_done, req_ackn_o, rx_read_o, tx_write_o;
    logic [5:0] cfg_o;
    logic [7:0] data_tx_o;
    logic [2:0] error_o;

    int         checkCount = 0;
    int         errorCount = 0;
    logic [5:0] refConfig;

    always #5 clk = ~clk;

    uart_main_controller dut (
        .clk_i(clk), .rst_n_i(rst_n), .interrupt_ackn_i(interrupt_ackn),
        .data_rx_i(data_rx), .data_tx_i(data_tx), .tx_done_i(tx_done), .req_done_i(req_done),
        .frame_error_i(frame_err), .parity_i(parity_err), .overrun_error_i(overrun_err),
        .configuration_error_i(config_err), .rx_fifo_empty_i(rx_empty), .tx_fifo_empty_i(tx_empty),
        .rx_fifo_read_i(rx_read), .tx_fifo_write_i(tx_write), .config_req_slv_i(req_slv),
        .config_req_mst_i(req_mst), .std_config_i(std_cfg), .config_i(cfg_in),
        .data_stream_mode_i(stream_mode), .req_ackn_i(req_ackn),
        .STR_en_o(str_en), .config_o(cfg_o), .config_req_mst_o(cfg_req_mst_o),
        .data_stream_mode_o(stream_mode_o), .configuration_done_o(cfg_done),
        .req_ackn_o(req_ackn_o), .rx_fifo_read_o(rx_read_o), .tx_fifo_write_o(tx_write_o),
        .data_tx_o(data_tx_o), .error_o(error_o)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        interrupt_ackn = 1'b0; tx_done = 1'b0; req_done = 1'b0;
        frame_err = 1'b0; parity_err = 1'b0; overrun_err = 1'b0; config_err = 1'b0;
        rx_empty = 1'b1; tx_empty = 1'b1; rx_read = 1'b0; tx_write = 1'b0;
        req_slv = 1'b0; req_mst = 1'b0; std_cfg = 1'b0; stream_mode = 1'b0; req_ackn = 1'b0;
        data_rx = 8'h00; data_tx = 8'h00; cfg_in = 6'h00;
    endtask

    // Master handshake seen from the remote side. abortAt<4 raises a configuration
    // error while waiting for that packet's ack.
    task automatic runMaster(input logic [5:0] cfg, input int abortAt, input logic [7:0] ackByte);
        logic [7:0] expPkt[4];
        bit         badAck;
`ifdef CONFIG_ACKN_CHECK_EN
        badAck = (ackByte != ACK);
`else
        badAck = 1'b0;
`endif
        expPkt[0] = {2'b01, 4'b0000, cfg[5:4]};
        expPkt[1] = {2'b10, 4'b0000, cfg[3:2]};
        expPkt[2] = {2'b11, 4'b0000, cfg[1:0]};
        expPkt[3] = 8'h00;
        cfg_in = cfg; req_mst = 1'b1;
        tick();
        req_mst = 1'b0; cfg_in = ~cfg;
        #1;
        checkValue("mst_str_en", str_en, 1);
        checkValue("mst_req_flag", cfg_req_mst_o, 1);
        repeat ($urandom_range(0, 3)) tick();
        checkValue("mst_str_hold", str_en, 1);
        req_done = 1'b1;
        tick();
        req_done = 1'b0;
        #1;
        checkValue("mst_str_off", str_en, 0);
        data_rx = ackByte; rx_empty = 1'b0;
        #1;
        checkValue("mst_req_ack_pop", rx_read_o, 1);
        tick();
        rx_empty = 1'b1;
        if (badAck) begin
            #1;
            checkValue("ackchk_flag", cfg_req_mst_o, 0);
            checkValue("ackchk_cfg", cfg_o, refConfig);
            checkValue("ackchk_err", error_o, 3'b100);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            checkValue($sformatf("mst_wr%0d", k), tx_write_o, 1);
            checkValue($sformatf("mst_pkt%0d", k), data_tx_o, expPkt[k]);
            tick();
            #1;
            checkValue($sformatf("mst_wr_once%0d", k), tx_write_o, 0);
            repeat ($urandom_range(0, 2)) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            if (k == abortAt) begin
                config_err = 1'b1;
                tick();
                config_err = 1'b0;
                #1;
                checkValue("abort_flag", cfg_req_mst_o, 0);
                checkValue("abort_cfg", cfg_o, refConfig);
                checkValue("abort_err", error_o, 3'b100);
                tx_write = 1'b1; data_tx = 8'hA5;
                #1;
                checkValue("abort_in_main", tx_write_o, 1);
                tx_write = 1'b0;
                return;
            end
            data_rx = ackByte; rx_empty = 1'b0;
            tick();
            rx_empty = 1'b1;
        end
        refConfig = cfg;
        #1;
        checkValue("mst_done", cfg_done, 1);
        checkValue("mst_cfg", cfg_o, cfg);
        checkValue("mst_flag_clr", cfg_req_mst_o, 0);
        tick();
        checkValue("mst_done_once", cfg_done, 0);
    endtask

    // Slave handshake: the remote sends three field packets then END
    task automatic runSlave(input logic [5:0] cfg);
        logic [7:0] pkt[4];
        pkt[0] = {2'b01, 4'b0000, cfg[5:4]};
        pkt[1] = {2'b10, 4'b0000, cfg[3:2]};
        pkt[2] = {2'b11, 4'b0000, cfg[1:0]};
        pkt[3] = 8'h00;
        req_slv = 1'b1;
        tick();
        req_slv = 1'b0;
        #1;
        checkValue("slv_req_ackn", req_ackn_o, 1);
        tick();
        checkValue("slv_req_ackn_once", req_ackn_o, 0);
        checkValue("slv_no_wr", tx_write_o, 0);
        req_ackn = 1'b1;
        #1;
        checkValue("slv_first_ack_wr", tx_write_o, 1);
        checkValue("slv_first_ack", data_tx_o, ACK);
        tick();
        req_ackn = 1'b0;
        for (int p = 0; p < 4; p++) begin
            repeat ($urandom_range(0, 2)) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            data_rx = pkt[p]; rx_empty = 1'b0;
            #1;
            checkValue($sformatf("slv_pop%0d", p), rx_read_o, 1);
            tick();
            rx_empty = 1'b1;
            #1;
            checkValue($sformatf("slv_ack_wr%0d", p), tx_write_o, 1);
            checkValue($sformatf("slv_ack%0d", p), data_tx_o, ACK);
            tick();
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        refConfig = cfg;
        #1;
        checkValue("slv_done", cfg_done, 1);
        checkValue("slv_cfg", cfg_o, cfg);
        tx_write = 1'b1; data_tx = 8'h3C;
        #1;
        checkValue("slv_back_main", data_tx_o, 8'h3C);
        tx_write = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] cfg;
        logic       rdv, emv, wrv, smv, smPrev;
        logic [7:0] dv;
        clearInputs();
        rst_n = 1'b0;
        refConfig = STD_CFG;
        repeat (3) @(posedge clk);
        #2;
        checkValue("rst_cfg", cfg_o, STD_CFG);
        checkValue("rst_err", error_o, 0);
        checkValue("rst_str", str_en, 0);
        checkValue("rst_mst_flag", cfg_req_mst_o, 0);
        checkValue("rst_stream", stream_mode_o, 0);
        checkValue("rst_done", cfg_done, 0);
        rst_n = 1'b1;
        tick();

        // Random MAIN traffic
        for (int i = 0; i < 25; i++) begin
            rdv = 1'($urandom); emv = 1'($urandom); wrv = 1'($urandom);
            smv = 1'($urandom); dv = 8'($urandom);
            rx_read = rdv; rx_empty = emv; tx_write = wrv; data_tx = dv; stream_mode = smv;
            #1;
            checkValue("main_rd", rx_read_o, rdv & ~emv);
            checkValue("main_wr", tx_write_o, wrv);
            checkValue("main_data", data_tx_o, dv);
            tick();
            checkValue("main_stream", stream_mode_o, smv);
            checkValue("main_cfg", cfg_o, refConfig);
        end
        clearInputs();
        tick();

        // Master configuration with a non-standard configuration
        do cfg = 6'($urandom); while (cfg == STD_CFG);
        runMaster(cfg, 4, ACK);
        clearInputs();

        // Standard-configuration load from the host
        std_cfg = 1'b1;
        tick();
        std_cfg = 1'b0;
        refConfig = STD_CFG;
        checkValue("std_load", cfg_o, STD_CFG);

        // Slave configuration: random fields then the standard ones
        do cfg = 6'($urandom); while (cfg == STD_CFG);
        runSlave(cfg);
        runSlave(STD_CFG);

        // Error latching and priority
        frame_err = 1'b1;
        tick();
        frame_err = 1'b0;
        checkValue("err_frame", error_o, 3'b001);
        repeat (3) tick();
        checkValue("err_frame_hold", error_o, 3'b001);
        interrupt_ackn = 1'b1;
        tick();
        interrupt_ackn = 1'b0;
        checkValue("err_clear", error_o, 3'b000);
        frame_err = 1'b1; overrun_err = 1'b1;
        tick();
        frame_err = 1'b0; overrun_err = 1'b0;
        checkValue("err_overrun_prio", error_o, 3'b011);
        parity_err = 1'b1; interrupt_ackn = 1'b1;
        tick();
        parity_err = 1'b0;
        checkValue("err_new_beats_clear", error_o, 3'b010);
        tick();
        interrupt_ackn = 1'b0;
        checkValue("err_clear2", error_o, 3'b000);

        // Abort during a master handshake
        do cfg = 6'($urandom); while (cfg == refConfig);
        runMaster(cfg, $urandom_range(0, 3), ACK);
        clearInputs();
        interrupt_ackn = 1'b1;
        tick();
        interrupt_ackn = 1'b0;
        checkValue("abort_err_clear", error_o, 3'b000);

        // Non-ACKN ack byte: aborts only when ack checking is built in
        do cfg = 6'($urandom); while (cfg == refConfig);
        runMaster(cfg, 4, 8'h55);
        clearInputs();
        interrupt_ackn = 1'b1;
        tick();
        interrupt_ackn = 1'b0;

        // Reset in the middle of a configuration
        cfg = ~STD_CFG;
        runMaster(cfg, 4, ACK);
        clearInputs();
        req_mst = 1'b1; cfg_in = STD_CFG;
        tick();
        req_mst = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        checkValue("midrst_cfg", cfg_o, STD_CFG);
        checkValue("midrst_flag", cfg_req_mst_o, 0);
        checkValue("midrst_str", str_en, 0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
